// File: rtl/median_window_if.sv
// -----------------------------------------------------------------------------
// median_window_if
// Handshake and output bundle that connects the raster source and the median
// sorting stage to median_window_gen.
//   start_i   : begin a frame (sampled only while the generator is idle)
//   pixel_i   : input pixel, row-major
//   valid_i   : pixel_i valid
//   ready_o   : generator accepts pixel_i (transfer on valid_i && ready_o)
//   window_o  : 3x3 window, tap k = 3*dr+dc at [k*PIXEL_W +: PIXEL_W]
//   valid_o   : window_o valid for this cycle only
//   done_o    : one-cycle pulse at frame end
// Modports: master = pixel source / window consumer, slave = the generator.
// -----------------------------------------------------------------------------
interface median_window_if #(
    parameter int PIXEL_W = 8
);
    logic                   start_i;
    logic [PIXEL_W-1:0]     pixel_i;
    logic                   valid_i;
    logic                   ready_o;
    logic [9*PIXEL_W-1:0]   window_o;
    logic                   valid_o;
    logic                   done_o;

    modport master (
        output start_i,
        output pixel_i,
        output valid_i,
        input  ready_o,
        input  window_o,
        input  valid_o,
        input  done_o
    );

    modport slave (
        input  start_i,
        input  pixel_i,
        input  valid_i,
        output ready_o,
        output window_o,
        output valid_o,
        output done_o
    );
endinterface

// File: rtl/median_window_gen.sv
// -----------------------------------------------------------------------------
// median_window_gen
// Raster-to-window front end for the median filter. Accepts one pixel per
// handshake in row-major order and emits one 3x3 neighbourhood per image
// pixel, centred on that pixel. Two lines plus three pixels are buffered; the
// frame tail is flushed internally with zero pseudo-pixels, then done_o pulses.
//
// Parameters : IMAGE_LEN (L, >= 2), IMAGE_HEIGHT (H, >= 2), PIXEL_W
// Ports      : clk  - single clock, rising edge
//              rst  - asynchronous, active-high reset
//              bus  - median_window_if.slave (start/pixel/valid/ready in,
//                     window/valid/done out)
//
// Optional feature macro: MEDIAN_WIN_REPLICATE_EN
//   defined   : out-of-image taps replicate the nearest edge pixel (row is
//               clamped first, then column)
//   undefined : out-of-image taps are zero
// -----------------------------------------------------------------------------
module median_window_gen #(
    parameter int IMAGE_LEN    = 1080,
    parameter int IMAGE_HEIGHT = 720,
    parameter int PIXEL_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    median_window_if.slave   bus
);

    // Incoming pixel plus 2L+2 stored pixels form the full history view.
    localparam int HIST_N = 2 * IMAGE_LEN + 3;
    localparam int TOTAL  = IMAGE_LEN * IMAGE_HEIGHT;
    localparam int N_W    = $clog2(TOTAL + IMAGE_LEN + 1);
    localparam int C_W    = $clog2(IMAGE_LEN);
    localparam int R_W    = $clog2(IMAGE_HEIGHT);

    localparam logic [N_W-1:0] N_FIRST_EMIT = N_W'(IMAGE_LEN + 1);
    localparam logic [N_W-1:0] N_LAST_PIX   = N_W'(TOTAL - 1);
    localparam logic [N_W-1:0] N_LAST_SHIFT = N_W'(TOTAL + IMAGE_LEN);
    localparam logic [C_W-1:0] COL_LAST     = C_W'(IMAGE_LEN - 1);
    localparam logic [R_W-1:0] ROW_LAST     = R_W'(IMAGE_HEIGHT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;

    logic                   ready_r;
    logic                   valid_r;
    logic                   done_r;
    logic [9*PIXEL_W-1:0]   window_r;

    logic [N_W-1:0]         n_cnt_r;   // linear index of the next shift
    logic [R_W-1:0]         row_r;     // row of the next centre to emit
    logic [C_W-1:0]         col_r;     // column of the next centre to emit

    logic                   accept_s;
    logic                   shift_s;
    logic                   clear_s;
    logic                   done_s;
    logic                   emit_s;
    logic [PIXEL_W-1:0]     shift_pix_s;

    logic [PIXEL_W-1:0]     hist_r      [0:HIST_N-2];
    logic [PIXEL_W-1:0]     hist_next_s [0:HIST_N-1];
    logic [PIXEL_W-1:0]     tap_s       [0:8];
    logic [9*PIXEL_W-1:0]   window_s;

    logic                   row_top_s;
    logic                   row_bot_s;
    logic                   col_left_s;
    logic                   col_right_s;

    assign accept_s = bus.valid_i & ready_r;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start_i) begin
                    state_next_s = ST_STREAM;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (accept_s && (n_cnt_r == N_LAST_PIX)) begin
                    state_next_s = ST_FLUSH;
                end else begin
                    state_next_s = ST_STREAM;
                end
            end
            ST_FLUSH: begin
                // n_cnt_r is the index of the flush shift happening now.
                if (n_cnt_r == N_LAST_SHIFT) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_FLUSH;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: shift enable, shifted value, counter clear, done request.
    always_comb begin
        shift_s     = 1'b0;
        shift_pix_s = {PIXEL_W{1'b0}};
        clear_s     = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                clear_s = bus.start_i;
            end
            ST_STREAM: begin
                shift_s     = accept_s;
                shift_pix_s = bus.pixel_i;
            end
            ST_FLUSH: begin
                shift_s     = 1'b1;
                shift_pix_s = {PIXEL_W{1'b0}};
            end
            ST_DONE: begin
                done_s = 1'b1;
            end
            default: begin
                shift_s = 1'b0;
            end
        endcase
    end

    // A shift emits a window once the centre index n-L-1 is non-negative.
    assign emit_s = shift_s & (n_cnt_r >= N_FIRST_EMIT);

    // Linear index and centre row/column counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_cnt_r <= {N_W{1'b0}};
            row_r   <= {R_W{1'b0}};
            col_r   <= {C_W{1'b0}};
        end else if (clear_s) begin
            n_cnt_r <= {N_W{1'b0}};
            row_r   <= {R_W{1'b0}};
            col_r   <= {C_W{1'b0}};
        end else begin
            if (shift_s) begin
                n_cnt_r <= n_cnt_r + {{(N_W-1){1'b0}}, 1'b1};
            end
            if (emit_s) begin
                if (col_r == COL_LAST) begin
                    col_r <= {C_W{1'b0}};
                    row_r <= row_r + {{(R_W-1){1'b0}}, 1'b1};
                end else begin
                    col_r <= col_r + {{(C_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    // History view as it will look after this cycle's shift; index 0 is the
    // newest pixel. The window is formed from this view so it can be
    // registered in the same cycle as the shift.
    assign hist_next_s[0] = shift_pix_s;
    for (genvar i = 1; i < HIST_N; i++) begin : g_hist_view
        assign hist_next_s[i] = hist_r[i-1];
    end

    // History shift register. Contents persist across frames; edge masking
    // makes stale data invisible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < HIST_N - 1; i++) begin
                hist_r[i] <= {PIXEL_W{1'b0}};
            end
        end else if (shift_s) begin
            for (int i = 0; i < HIST_N - 1; i++) begin
                hist_r[i] <= hist_next_s[i];
            end
        end else begin
            for (int i = 0; i < HIST_N - 1; i++) begin
                hist_r[i] <= hist_r[i];
            end
        end
    end

    assign row_top_s   = (row_r == {R_W{1'b0}});
    assign row_bot_s   = (row_r == ROW_LAST);
    assign col_left_s  = (col_r == {C_W{1'b0}});
    assign col_right_s = (col_r == COL_LAST);

    // Tap (dr,dc) lives at offset (2-dr)*L + (2-dc) from the newest pixel.
    for (genvar dr = 0; dr < 3; dr++) begin : g_row
        for (genvar dc = 0; dc < 3; dc++) begin : g_col
            localparam int K       = 3 * dr + dc;
            localparam int IDX     = (2 - dr) * IMAGE_LEN + (2 - dc);
            localparam int IDX_R1  = IMAGE_LEN + (2 - dc);       // row clamped
            localparam int IDX_C1  = (2 - dr) * IMAGE_LEN + 1;   // column clamped
            localparam int IDX_CTR = IMAGE_LEN + 1;              // both clamped

            logic row_out_s;
            logic col_out_s;

            assign row_out_s = (dr == 0) ? row_top_s  :
                               (dr == 2) ? row_bot_s  : 1'b0;
            assign col_out_s = (dc == 0) ? col_left_s :
                               (dc == 2) ? col_right_s : 1'b0;

`ifdef MEDIAN_WIN_REPLICATE_EN
            // Clamping an offset onto the image edge selects the middle
            // row/column tap; corners therefore take the centre pixel.
            assign tap_s[K] = row_out_s ? (col_out_s ? hist_next_s[IDX_CTR] : hist_next_s[IDX_R1])
                                        : (col_out_s ? hist_next_s[IDX_C1]  : hist_next_s[IDX]);
`else
            assign tap_s[K] = (row_out_s | col_out_s) ? {PIXEL_W{1'b0}} : hist_next_s[IDX];
`endif
            assign window_s[K*PIXEL_W +: PIXEL_W] = tap_s[K];
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_r  <= 1'b0;
            valid_r  <= 1'b0;
            done_r   <= 1'b0;
            window_r <= {(9*PIXEL_W){1'b0}};
        end else begin
            ready_r <= (state_next_s == ST_STREAM);
            valid_r <= emit_s;
            done_r  <= done_s;
            if (emit_s) begin
                window_r <= window_s;
            end else begin
                window_r <= window_r;
            end
        end
    end

    assign bus.ready_o  = ready_r;
    assign bus.valid_o  = valid_r;
    assign bus.done_o   = done_r;
    assign bus.window_o = window_r;

endmodule

// File: tb/tb_median_window_gen.sv
// -----------------------------------------------------------------------------
// tb_median_window_gen
// Directed bench for median_window_gen with L=4, H=3, PIXEL_W=8 and pixel
// value n+1 at linear index n. Expected windows come from image coordinates
// (row/column arithmetic on the 4x3 image), plus hand-written first/last
// windows. Honours MEDIAN_WIN_REPLICATE_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_median_window_gen;

    localparam int L  = 4;
    localparam int H  = 3;
    localparam int PW = 8;

`ifdef MEDIAN_WIN_REPLICATE_EN
    localparam logic [71:0] FIRST_WIN = 72'h06_05_05_02_01_01_02_01_01;
    localparam logic [71:0] LAST_WIN  = 72'h0C_0C_0B_0C_0C_0B_08_08_07;
`else
    localparam logic [71:0] FIRST_WIN = 72'h06_05_00_02_01_00_00_00_00;
    localparam logic [71:0] LAST_WIN  = 72'h00_00_00_00_0C_0B_00_08_07;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    median_window_if #(.PIXEL_W(PW)) bus ();

    median_window_gen #(
        .IMAGE_LEN    (L),
        .IMAGE_HEIGHT (H),
        .PIXEL_W      (PW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen = 0;
    logic [71:0] win_q [$];

    // Capture every emitted window and count done pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.valid_o === 1'b1) win_q.push_back(bus.window_o);
        if (bus.done_o === 1'b1) done_seen++;
    end

    function automatic logic [71:0] exp_win(input int m);
        logic [71:0] w;
        int r, c, rr, cc;
        w = '0;
        r = m / L;
        c = m % L;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                rr = r + dr - 1;
                cc = c + dc - 1;
`ifdef MEDIAN_WIN_REPLICATE_EN
                if (rr < 0) rr = 0;
                if (rr > H - 1) rr = H - 1;
                if (cc < 0) cc = 0;
                if (cc > L - 1) cc = L - 1;
                w[(3*dr+dc)*8 +: 8] = 8'(rr * L + cc + 1);
`else
                if (rr >= 0 && rr < H && cc >= 0 && cc < L)
                    w[(3*dr+dc)*8 +: 8] = 8'(rr * L + cc + 1);
`endif
            end
        end
        return w;
    endfunction

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // One full frame; optional stalls, a stray start pulse, valid held in flush.
    task automatic run_frame(input bit stalls, input bit poke_start, input bit hold_valid);
        int stall_tab [12] = '{0, 2, 0, 1, 3, 0, 0, 1, 0, 2, 1, 0};
        win_q.delete();
        done_seen = 0;
        check("idle_ready", 72'(bus.ready_o), 72'(0));
        bus.start_i = 1'b1;
        cycle();
        bus.start_i = 1'b0;
        check("ready_rise", 72'(bus.ready_o), 72'(1));
        for (int n = 0; n < L * H; n++) begin
            if (stalls) begin
                for (int s = 0; s < stall_tab[n]; s++) begin
                    bus.valid_i = 1'b0;
                    cycle();
                    check("stall_gap", 72'(bus.valid_o), 72'(0));
                end
            end
            bus.valid_i = 1'b1;
            bus.pixel_i = 8'(n + 1);
            bus.start_i = poke_start && (n == 3);
            cycle();
            bus.start_i = 1'b0;
            check("valid_after_accept", 72'(bus.valid_o), 72'(n >= 5));
            if (n == 5) check("first_window", bus.window_o, FIRST_WIN);
        end
        bus.valid_i = hold_valid;
        bus.pixel_i = 8'hAA;
        check("flush_ready", 72'(bus.ready_o), 72'(0));
        for (int i = 1; i <= L + 1; i++) begin
            cycle();
            check("flush_ready", 72'(bus.ready_o), 72'(0));
            check("flush_valid", 72'(bus.valid_o), 72'(1));
        end
        check("last_window", bus.window_o, LAST_WIN);
        cycle();
        check("done_pulse", 72'(bus.done_o), 72'(1));
        check("valid_after_last", 72'(bus.valid_o), 72'(0));
        cycle();
        check("done_single", 72'(bus.done_o), 72'(0));
        check("idle_ready_after", 72'(bus.ready_o), 72'(0));
        bus.valid_i = 1'b0;
        check("window_count", 72'(win_q.size()), 72'(L * H));
        for (int m = 0; m < L * H && m < win_q.size(); m++) begin
            check("window_seq", win_q[m], exp_win(m));
        end
        check("done_count", 72'(done_seen), 72'(1));
    endtask

    initial begin
        rst         = 1'b1;
        bus.start_i = 1'b0;
        bus.valid_i = 1'b0;
        bus.pixel_i = 8'h00;
        cycle();
        check("rst_ready",  72'(bus.ready_o), 72'(0));
        check("rst_valid",  72'(bus.valid_o), 72'(0));
        check("rst_done",   72'(bus.done_o),  72'(0));
        check("rst_window", bus.window_o,     72'(0));
        rst = 1'b0;
        cycle();
        cycle();
        check("idle_no_ready", 72'(bus.ready_o), 72'(0));

        // Stall-free frame.
        run_frame(1'b0, 1'b0, 1'b0);

        // Frame with input stalls.
        run_frame(1'b1, 1'b0, 1'b0);

        // Reset after 7 accepts.
        win_q.delete();
        done_seen = 0;
        bus.start_i = 1'b1;
        cycle();
        bus.start_i = 1'b0;
        for (int n = 0; n < 7; n++) begin
            bus.valid_i = 1'b1;
            bus.pixel_i = 8'(n + 1);
            cycle();
        end
        check("pre_rst_valid", 72'(bus.valid_o), 72'(1));
        bus.valid_i = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_ready",  72'(bus.ready_o), 72'(0));
        check("mid_rst_valid",  72'(bus.valid_o), 72'(0));
        check("mid_rst_done",   72'(bus.done_o),  72'(0));
        check("mid_rst_window", bus.window_o,     72'(0));
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        cycle();
        check("mid_rst_no_done", 72'(done_seen), 72'(0));
        run_frame(1'b0, 1'b0, 1'b0);

        // Stray start during STREAM and valid held during FLUSH.
        run_frame(1'b0, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
